bmu_result_buffer: RTL and testbench

// - Downstream of the BMU: captures each BMU result (resultFf, error) LAT cycles after issue, tags it, queues it in a DEPTH-entry FIFO.
// - Presents results to writeback over a valid/ready handshake; BMU itself cannot stall.
// - Gives upstream issue logic a credit signal (issueReadyOut) so in-flight ops never overrun the FIFO.

---
 rtl/bmu_result_buffer_if.sv | 49 ++++
 rtl/bmu_result_buffer.sv | 150 +++++++++++++++
 tb/tb_bmu_result_buffer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bmu_result_buffer_if.sv
// ----------------------------------------------------------------------------
// bmu_result_buffer_if
// Groups the BMU capture inputs, the writeback handshake and the status
// outputs of bmu_result_buffer into one bundle.
//   slave  : the buffer's view (BMU side and wbReadyIn in, wb*/status out)
//   master : the environment's view (drives BMU side and wbReadyIn)
// Parameters:
//   DEPTH : FIFO entries, sets the countOut width ($clog2(DEPTH+1))
//   TAG_W : destination tag width
//   CNT_W : saturating error counter width
// ----------------------------------------------------------------------------
interface bmu_result_buffer_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  // BMU side
  logic             bmuValidIn;
  logic [TAG_W-1:0] tagIn;
  logic [31:0]      resultFfIn;
  logic             errorIn;
  logic             issueReadyOut;

  // Writeback side
  logic             wbValidOut;
  logic             wbReadyIn;
  logic [31:0]      wbDataOut;
  logic [TAG_W-1:0] wbTagOut;
  logic             wbErrorOut;

  // Status
  logic [CW-1:0]    countOut;
  logic             overflowOut;
  logic [CNT_W-1:0] errCountOut;

  modport slave (
    input  bmuValidIn, tagIn, resultFfIn, errorIn, wbReadyIn,
    output issueReadyOut, wbValidOut, wbDataOut, wbTagOut, wbErrorOut,
           countOut, overflowOut, errCountOut
  );

  modport master (
    output bmuValidIn, tagIn, resultFfIn, errorIn, wbReadyIn,
    input  issueReadyOut, wbValidOut, wbDataOut, wbTagOut, wbErrorOut,
           countOut, overflowOut, errCountOut
  );
endinterface

// File: rtl/bmu_result_buffer.sv
// ----------------------------------------------------------------------------
// bmu_result_buffer
// Captures each BMU result LAT cycles after its issue, tags it and queues it
// in a DEPTH-entry FIFO that drains to writeback over valid/ready. The BMU
// cannot stall, so issueReadyOut grants issue credit only while queued plus
// in-flight ops fit in the FIFO.
// Ports:
//   clk  : clock, all state on posedge
//   rstL : asynchronous active-low reset
//   bus  : bmu_result_buffer_if.slave (BMU capture, writeback, status)
// Configuration:
//   BMU_RESBUF_BYPASS_EN : when defined, a result arriving at an empty FIFO
//     with wbReadyIn=1 goes straight to wb*Out in the capture cycle and is
//     not pushed. Undefined: wb*Out come only from registered FIFO storage.
// ----------------------------------------------------------------------------
module bmu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int LAT   = 1,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rstL,
  bmu_result_buffer_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  logic [LAT-1:0]   r_dl_valid;
  logic [TAG_W-1:0] r_dl_tag [LAT];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic [CNT_W-1:0] r_err_cnt;
  entry_t           r_mem [DEPTH];

  logic             w_cap;
  logic [TAG_W-1:0] w_cap_tag;
  logic             w_full;
  logic             w_pop;
  logic             w_bypass;
  logic             w_push;
  logic             w_drop;
  int               w_inflight;
  entry_t           w_head;
  logic             w_wb_valid;
  logic [31:0]      w_wb_data;
  logic [TAG_W-1:0] w_wb_tag;
  logic             w_wb_err;

  // Delay line: stage 0 samples the issue, stage LAT-1 is the capture strobe.
  // NOTE: all sequential state uses non-blocking assignments so every stage
  // shifts from its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      r_dl_valid <= '0;
      for (int i = 0; i < LAT; i++) r_dl_tag[i] <= '0;
    end else begin
      r_dl_valid[0] <= bus.bmuValidIn;
      r_dl_tag[0]   <= bus.tagIn;
      for (int i = 1; i < LAT; i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        r_dl_tag[i]   <= r_dl_tag[i-1];
      end
    end
  end

  assign w_cap     = r_dl_valid[LAT-1];
  assign w_cap_tag = r_dl_tag[LAT-1];

  always_comb begin
    w_inflight = 0;
    for (int i = 0; i < LAT; i++) w_inflight += int'(r_dl_valid[i]);
  end

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = (r_count != '0) && bus.wbReadyIn;

`ifdef BMU_RESBUF_BYPASS_EN
  assign w_bypass = (r_count == '0) && w_cap && bus.wbReadyIn;
`else
  assign w_bypass = 1'b0;
`endif

  // A capture into a full FIFO survives only if the head leaves this cycle.
  assign w_push = w_cap && !w_bypass && (!w_full || w_pop);
  assign w_drop = w_cap && !w_bypass && w_full && !w_pop;

  // NOTE: the storage array has no reset; nothing reads it until an entry is
  // written, and the outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{data: bus.resultFfIn, tag: w_cap_tag, err: bus.errorIn};
  end

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
      // A bypassed result is delivered, so its error is counted like a push.
      if ((w_push || w_bypass) && bus.errorIn && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_wb_valid = (r_count != '0);
    w_wb_data  = w_wb_valid ? w_head.data : '0;
    w_wb_tag   = w_wb_valid ? w_head.tag  : '0;
    w_wb_err   = w_wb_valid ? w_head.err  : 1'b0;
`ifdef BMU_RESBUF_BYPASS_EN
    if (w_bypass) begin
      w_wb_valid = 1'b1;
      w_wb_data  = bus.resultFfIn;
      w_wb_tag   = w_cap_tag;
      w_wb_err   = bus.errorIn;
    end
`endif
  end

  // Credit ignores a same-cycle pop: conservative but purely registered.
  assign bus.issueReadyOut = (int'(r_count) + w_inflight) < DEPTH;
  assign bus.wbValidOut    = w_wb_valid;
  assign bus.wbDataOut     = w_wb_data;
  assign bus.wbTagOut      = w_wb_tag;
  assign bus.wbErrorOut    = w_wb_err;
  assign bus.countOut      = r_count;
  assign bus.overflowOut   = r_overflow;
  assign bus.errCountOut   = r_err_cnt;
endmodule

// File: tb/tb_bmu_result_buffer.sv
// ----------------------------------------------------------------------------
// tb_bmu_result_buffer
// Directed bench for bmu_result_buffer (DEPTH=4, LAT=1, TAG_W=5). Each issued
// op's expected writeback beat goes into a scoreboard queue when its result
// is presented; a negedge monitor pops and compares on every accepted beat.
// A second instance with CNT_W=2 shares the stimulus to show counter
// saturation. Honours BMU_RESBUF_BYPASS_EN when defined.
// ----------------------------------------------------------------------------
module tb_bmu_result_buffer;
  localparam int DEPTH = 4;

  logic clk;
  logic rstL;

  bmu_result_buffer_if #(.DEPTH(DEPTH), .TAG_W(5), .CNT_W(8)) bus ();
  bmu_result_buffer_if #(.DEPTH(DEPTH), .TAG_W(5), .CNT_W(2)) sbus ();

  bmu_result_buffer #(.DEPTH(DEPTH), .LAT(1), .TAG_W(5), .CNT_W(8)) dut (
    .clk(clk), .rstL(rstL), .bus(bus)
  );
  bmu_result_buffer #(.DEPTH(DEPTH), .LAT(1), .TAG_W(5), .CNT_W(2)) dut_small (
    .clk(clk), .rstL(rstL), .bus(sbus)
  );

  assign sbus.bmuValidIn = bus.bmuValidIn;
  assign sbus.tagIn      = bus.tagIn;
  assign sbus.resultFfIn = bus.resultFfIn;
  assign sbus.errorIn    = bus.errorIn;
  assign sbus.wbReadyIn  = bus.wbReadyIn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference state: occupancy, sticky overflow, error count, pending op.
  int          m_count = 0;
  logic        m_ovf   = 1'b0;
  int          m_err   = 0;
  logic        p_v     = 1'b0;
  logic [4:0]  p_tag   = '0;
  logic [31:0] p_data  = '0;
  logic        p_err   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstL && bus.wbValidOut && bus.wbReadyIn) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL sb_unexpected: got tag %0d data 0x%08h, expected no beat", bus.wbTagOut, bus.wbDataOut);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_data", bus.wbDataOut, e.data);
        check("wb_tag", 32'(bus.wbTagOut), 32'(e.tag));
        check("wb_err", 32'(bus.wbErrorOut), 32'(e.err));
      end
    end
  end

  // Drive one cycle: a new issue (v/tag) plus the result of last cycle's
  // issue (LAT=1), and update the reference model for the coming edge.
  task automatic drive(input logic v, input logic [4:0] tag, input logic [31:0] data,
                       input logic err, input logic rdy);
    logic pop;
    logic byp;
    exp_t e;
    bus.bmuValidIn = v;
    bus.tagIn      = tag;
    bus.wbReadyIn  = rdy;
    bus.resultFfIn = p_v ? p_data : 32'h0;
    bus.errorIn    = p_v ? p_err : 1'b0;
    pop = (m_count != 0) && rdy;
    byp = 1'b0;
`ifdef BMU_RESBUF_BYPASS_EN
    byp = (m_count == 0) && p_v && rdy;
`endif
    if (p_v) begin
      if (byp || m_count < DEPTH || pop) begin
        e.data = p_data;
        e.tag  = p_tag;
        e.err  = p_err;
        sb.push_back(e);
        if (p_err) m_err++;
        if (!byp) m_count++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (pop) m_count--;
    p_v    = v;
    p_tag  = tag;
    p_data = data;
    p_err  = err;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    check("count", 32'(bus.countOut), 32'(m_count));
    check("overflow", 32'(bus.overflowOut), 32'(m_ovf));
    check("err_count", 32'(bus.errCountOut), 32'(m_err));
    check("err_count_sat2", 32'(sbus.errCountOut), 32'((m_err > 3) ? 3 : m_err));
    check("issue_ready", 32'(bus.issueReadyOut), 32'((m_count + int'(p_v)) < DEPTH));
  endtask

  task automatic step(input logic v, input logic [4:0] tag, input logic [31:0] data,
                      input logic err, input logic rdy);
    drive(v, tag, data, err, rdy);
    advance();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rstL           = 1'b0;
    bus.bmuValidIn = 1'b0;
    bus.tagIn      = '0;
    bus.resultFfIn = '0;
    bus.errorIn    = 1'b0;
    bus.wbReadyIn  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", 32'(bus.wbValidOut), 32'd0);
    check("rst_wb_data", bus.wbDataOut, 32'd0);
    check("rst_wb_tag", 32'(bus.wbTagOut), 32'd0);
    check("rst_wb_err", 32'(bus.wbErrorOut), 32'd0);
    check("rst_issue_ready", 32'(bus.issueReadyOut), 32'd1);
    check("rst_count", 32'(bus.countOut), 32'd0);
    rstL = 1'b1;
    @(posedge clk);
    #1;

    // Single op, latency LAT+1, held while not ready, then popped.
    step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("single_valid", 32'(bus.wbValidOut), 32'd1);
    check("single_data", bus.wbDataOut, 32'hDEADBEEF);
    check("single_tag", 32'(bus.wbTagOut), 32'd3);
    check("single_count", 32'(bus.countOut), 32'd1);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("single_hold_data", bus.wbDataOut, 32'hDEADBEEF);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("single_popped", 32'(bus.countOut), 32'd0);

    // Four back-to-back issues, three carrying errors.
    step(1'b1, 5'd1, 32'hA000_0001, 1'b1, 1'b0);
    step(1'b1, 5'd2, 32'hA000_0002, 1'b1, 1'b0);
    step(1'b1, 5'd3, 32'hA000_0003, 1'b1, 1'b0);
    step(1'b1, 5'd4, 32'hA000_0004, 1'b0, 1'b0);
    check("credit_exhausted", 32'(bus.issueReadyOut), 32'd0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("full_count", 32'(bus.countOut), 32'd4);
    check("err3", 32'(bus.errCountOut), 32'd3);

    // Capture into a full FIFO while the head pops: accepted.
    step(1'b1, 5'd10, 32'hA000_000A, 1'b1, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("fullpop_count", 32'(bus.countOut), 32'd4);
    check("fullpop_ovf", 32'(bus.overflowOut), 32'd0);

    // Capture into a full FIFO with no pop: dropped, overflow sticky.
    step(1'b1, 5'd9, 32'h9999_9999, 1'b1, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("drop_ovf", 32'(bus.overflowOut), 32'd1);
    check("drop_count", 32'(bus.countOut), 32'd4);
    check("drop_err_uncounted", 32'(bus.errCountOut), 32'd4);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("ovf_sticky", 32'(bus.overflowOut), 32'd1);

    // Drain: tags 2,3,4,10 in order; credit returns after the first pop.
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("credit_after_pop", 32'(bus.issueReadyOut), 32'd1);
    repeat (3) step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("drained_count", 32'(bus.countOut), 32'd0);

    // Empty FIFO, ready high: bypass delivers in the capture cycle.
    step(1'b1, 5'd6, 32'h6666_6666, 1'b1, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    #1;
`ifdef BMU_RESBUF_BYPASS_EN
    check("bypass_valid", 32'(bus.wbValidOut), 32'd1);
    check("bypass_data", bus.wbDataOut, 32'h6666_6666);
    advance();
    check("bypass_count", 32'(bus.countOut), 32'd0);
`else
    check("nobypass_valid", 32'(bus.wbValidOut), 32'd0);
    advance();
    check("nobypass_count", 32'(bus.countOut), 32'd1);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
`endif
    check("err5", 32'(bus.errCountOut), 32'd5);
    check("err_sat_cnt2", 32'(sbus.errCountOut), 32'd3);

    // Mixed traffic across pointer wrap with ready toggling.
    for (int i = 0; i < 8; i++)
      step(1'b1, 5'(16 + i), 32'hC0DE_0000 + 32'(i), 1'(i & 1), (i % 3) != 0);
    for (int i = 0; i < 8; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("wrap_drained", 32'(bus.countOut), 32'd0);

    // Reset in the middle of traffic.
    step(1'b1, 5'd7, 32'h7777_7777, 1'b0, 1'b0);
    step(1'b1, 5'd8, 32'h8888_8888, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("pre_reset_count", 32'(bus.countOut), 32'd2);
    rstL = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.wbValidOut), 32'd0);
    check("midrst_count", 32'(bus.countOut), 32'd0);
    check("midrst_ovf", 32'(bus.overflowOut), 32'd0);
    check("midrst_err", 32'(bus.errCountOut), 32'd0);
    check("midrst_ready", 32'(bus.issueReadyOut), 32'd1);
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_err   = 0;
    p_v     = 1'b0;
    bus.bmuValidIn = 1'b0;
    bus.wbReadyIn  = 1'b0;
    @(posedge clk);
    #1;
    rstL = 1'b1;

    // Recovery after reset.
    step(1'b1, 5'd5, 32'h5555_5555, 1'b0, 1'b1);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
